// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, forward S-box table and SubBytes FSM encoding
package aes_pkg;
    typedef logic [127:0] aes_state_t;
    typedef logic [7:0] aes_byte_t;
    localparam int AES_NBYTES = 16;
    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    typedef enum logic [1:0] {IDLE, SUB, DONE} subbytes_state_e;
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational one-byte forward S-box lookup
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    assign byte_o = SBOX[byte_i];
endmodule

// File: rtl/aes_subbytes_seq.sv
// aes_subbytes_seq: forward SubBytes over a valid/ready handshake, LANES bytes per cycle
module aes_subbytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int STEPS = AES_NBYTES / LANES;
    localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("aes_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
    subbytes_state_e fsm_q, fsm_d;
    logic [127:0] state_q, state_d, sub_state;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0] base;
    aes_byte_t cur_b [AES_NBYTES];
    aes_byte_t nxt_b [AES_NBYTES];
    aes_byte_t lane_in [LANES];
    aes_byte_t lane_out [LANES];
    assign base = 4'(32'(cnt_q) * LANES);
    always_comb begin
        for (int i = 0; i < AES_NBYTES; i++) cur_b[i] = state_q[127-8*i -: 8];
    end
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_in[g] = cur_b[base + 4'(g)];
        aes_sbox u_sbox (.byte_i(lane_in[g]), .byte_o(lane_out[g]));
    end
    // Only the LANES bytes selected by the counter are replaced this cycle
    always_comb begin
        nxt_b = cur_b;
        sub_state = '0;
        for (int l = 0; l < LANES; l++) nxt_b[base + 4'(l)] = lane_out[l];
        for (int i = 0; i < AES_NBYTES; i++) sub_state[127-8*i -: 8] = nxt_b[i];
    end
    always_comb begin
        fsm_d = fsm_q;
        state_d = state_q;
        cnt_d = cnt_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_data;
                    cnt_d = '0;
                    fsm_d = SUB;
                end
            end
            SUB: begin
                state_d = sub_state;
                cnt_d = cnt_q + 1'b1;
                fsm_d = cnt_q == LAST ? DONE : SUB;
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = in_valid ? SUB : IDLE;
                    state_d = in_valid ? in_data : state_q;
                    cnt_d = '0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= IDLE;
            state_q <= '0;
            cnt_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
    assign in_ready = rst_n && (fsm_q == IDLE || (fsm_q == DONE && out_ready));
    assign out_valid = fsm_q == DONE;
    assign busy = fsm_q != IDLE;
    assign out_data = state_q;
endmodule

// File: tb/tb_aes_subbytes_seq.sv
// tb_aes_subbytes_seq: directed checks of aes_subbytes_seq for LANES = 1, 2, 4, 8, 16
module tb_aes_subbytes_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [4:0] ir, ov, bz;
    logic [127:0] od [5];
    int checks = 0;
    int failures = 0;
    localparam logic [127:0] ORDER_IN  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] ORDER_OUT = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ZERO_OUT  = {16{8'h63}};
    localparam logic [127:0] FF_OUT    = {16{8'h16}};
    localparam logic [127:0] S53_IN    = {16{8'h53}};
    localparam logic [127:0] S53_OUT   = {16{8'hed}};
    always #5 clk = ~clk;
    for (genvar k = 0; k < 5; k++) begin : g_dut
        aes_subbytes_seq #(.LANES(1 << k)) u_dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[k]),
            .in_data(in_data), .out_valid(ov[k]), .out_ready(out_ready),
            .out_data(od[k]), .busy(bz[k])
        );
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!ov[2] && cyc < 40) begin
            step;
            cyc++;
        end
    endtask
    task automatic send(input logic [127:0] d, output int cyc);
        in_data = d;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        wait_out(cyc);
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        in_data = '1;
        step;
        step;
        checks++;
        if (ov[2] !== 1'b0 || bz[2] !== 1'b0 || ir[2] !== 1'b0 || od[2] !== '0) begin
            failures++;
            $display("FAIL reset_state: out_valid=%b busy=%b in_ready=%b out_data=%h, want 0 0 0 0", ov[2], bz[2], ir[2], od[2]);
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step;
        checks++;
        if (ir[2] !== 1'b1 || bz[2] !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: in_ready=%b busy=%b, want 1 0", ir[2], bz[2]);
        end
    endtask
    task automatic test_zero;
        int cyc;
        out_ready = 1'b1;
        send('0, cyc);
        checks++;
        if (cyc != 4) begin
            failures++;
            $display("FAIL zero_latency: got %0d cycles, want 4", cyc);
        end
        checks++;
        if (od[2] !== ZERO_OUT) begin
            failures++;
            $display("FAIL zero_data: got %h, want %h", od[2], ZERO_OUT);
        end
        step;
        checks++;
        if (ov[2] !== 1'b0 || bz[2] !== 1'b0) begin
            failures++;
            $display("FAIL zero_drain: out_valid=%b busy=%b, want 0 0", ov[2], bz[2]);
        end
    endtask
    task automatic test_order;
        int cyc;
        send(ORDER_IN, cyc);
        checks++;
        if (od[2] !== ORDER_OUT || cyc != 4) begin
            failures++;
            $display("FAIL order_data: got %h after %0d cycles, want %h after 4", od[2], cyc, ORDER_OUT);
        end
        step;
    endtask
    task automatic test_backpressure;
        int cyc;
        int bad;
        out_ready = 1'b0;
        send(ORDER_IN, cyc);
        checks++;
        if (ov[2] !== 1'b1 || od[2] !== ORDER_OUT) begin
            failures++;
            $display("FAIL bp_start: out_valid=%b out_data=%h, want 1 %h", ov[2], od[2], ORDER_OUT);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step;
            if (ov[2] !== 1'b1 || od[2] !== ORDER_OUT || ir[2] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_hold: %0d of 10 cycles lost valid/data or raised in_ready, want 0", bad);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (ir[2] !== 1'b1) begin
            failures++;
            $display("FAIL bp_ready_comb: in_ready=%b, want 1", ir[2]);
        end
        step;
        checks++;
        if (ov[2] !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b, want 0", ov[2]);
        end
    endtask
    task automatic test_back_to_back;
        int cyc;
        out_ready = 1'b1;
        in_data = '0;
        in_valid = 1'b1;
        step;
        in_data = '1;
        wait_out(cyc);
        checks++;
        if (cyc != 4 || od[2] !== ZERO_OUT) begin
            failures++;
            $display("FAIL b2b_first: got %h after %0d cycles, want %h after 4", od[2], cyc, ZERO_OUT);
        end
        checks++;
        if (ir[2] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: in_ready=%b, want 1", ir[2]);
        end
        step;
        in_valid = 1'b0;
        checks++;
        if (bz[2] !== 1'b1 || ov[2] !== 1'b0 || ir[2] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: busy=%b out_valid=%b in_ready=%b, want 1 0 0", bz[2], ov[2], ir[2]);
        end
        wait_out(cyc);
        checks++;
        if (cyc != 4 || od[2] !== FF_OUT) begin
            failures++;
            $display("FAIL b2b_second: got %h after %0d cycles, want %h after 4", od[2], cyc, FF_OUT);
        end
        step;
    endtask
    task automatic test_reset_mid;
        int cyc;
        in_data = ORDER_IN;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        step;
        step;
        rst_n = 1'b0;
        step;
        checks++;
        if (ov[2] !== 1'b0 || bz[2] !== 1'b0 || od[2] !== '0 || ir[2] !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: out_valid=%b busy=%b out_data=%h in_ready=%b, want 0 0 0 0", ov[2], bz[2], od[2], ir[2]);
        end
        rst_n = 1'b1;
        step;
        send(S53_IN, cyc);
        checks++;
        if (cyc != 4 || od[2] !== S53_OUT) begin
            failures++;
            $display("FAIL mid_fresh: got %h after %0d cycles, want %h after 4", od[2], cyc, S53_OUT);
        end
        step;
    endtask
    task automatic test_sweep;
        int lat [5];
        logic [127:0] got [5];
        for (int k = 0; k < 5; k++) begin
            lat[k] = 0;
            got[k] = '0;
        end
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step;
        in_data = ORDER_IN;
        in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            step;
            for (int k = 0; k < 5; k++) begin
                if (ov[k] && lat[k] == 0) begin
                    lat[k] = c;
                    got[k] = od[k];
                end
            end
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (lat[k] != (16 >> k)) begin
                failures++;
                $display("FAIL sweep_latency LANES=%0d: got %0d cycles, want %0d", 1 << k, lat[k], 16 >> k);
            end
            checks++;
            if (got[k] !== ORDER_OUT) begin
                failures++;
                $display("FAIL sweep_data LANES=%0d: got %h, want %h", 1 << k, got[k], ORDER_OUT);
            end
        end
    endtask
    initial begin
        test_reset;
        test_zero;
        test_order;
        test_backpressure;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_subbytes_seq.md
Name: aes_subbytes_seq

Overview:
- Forward AES SubBytes stage for the encryption datapath; the counterpart of the inverse SubBytes used in decryption.
- Accepts one 128-bit state over a valid/ready handshake and substitutes its 16 bytes through LANES shared forward S-boxes, LANES bytes per cycle.
- Presents the substituted state on a valid/ready output. It sits between AddRoundKey and ShiftRows in the iterative encryption round.

Parameters:
- LANES, 4, bytes substituted per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  in_data holds a state to accept
- in_ready  output  1  block can accept a state this cycle
- in_data  input  128  input state; byte i = [127-8i:120-8i], byte 0 is the MSB byte
- out_valid  output  1  out_data holds a completed result
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  substituted state, same byte ordering as in_data
- busy  output  1  high in SUB or DONE

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-low, sampled only at the rising edge of clk.
- Reset values: FSM is IDLE, state register is 0, byte counter is 0, out_valid=0, busy=0. in_ready is forced to 0 while rst_n=0.
- FSM states: IDLE, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture in_data into the state register, clear the counter, go to SUB.
- SUB:
  - in_ready=0.
  - On each edge, bytes cnt*LANES .. cnt*LANES+LANES-1 are replaced by sbox(byte), then cnt increments.
  - When cnt reaches 16/LANES-1 on an edge, go to DONE.
  - in_valid is ignored throughout SUB.
- DONE:
  - out_valid=1. out_data is the state register and is held stable until the handshake completes.
  - out_valid stays high while out_ready=0, with no change to out_data.
  - On an edge with out_ready=1 and in_valid=0: go to IDLE, out_valid falls.
  - On an edge with out_ready=1 and in_valid=1: accept the new state on that same edge and go to SUB (back-to-back operation).
  - in_ready = out_ready in DONE, computed combinationally.
- Latency: a state accepted at edge N gives out_valid=1 after edge N+16/LANES (4 cycles for LANES=4, 1 cycle for LANES=16).
- Throughput: one state per 16/LANES+1 cycles with downstream always ready.
- Arithmetic: S-box is the FIPS-197 forward table, pure lookup. Counter width is clog2(16/LANES) with a minimum of 1 bit. The counter wraps to 0 on entry to SUB and is never read outside SUB.
- Reset mid-operation: rst_n=0 during SUB or DONE discards the state. On the next cycle: IDLE, out_valid=0, out_data=0.
- busy = (FSM != IDLE). There is no bypass path from in_data to out_data.

Decomposition:
- Shared package aes_pkg holds:
  - typedef aes_state_t (128-bit) and aes_byte_t (8-bit)
  - constant AES_NBYTES=16
  - the forward SBOX table constant, shared with future key-expansion logic
  - FSM state enum subbytes_state_e
- Sub-module aes_sbox: one-byte forward S-box lookup from the package table, combinational, instantiated LANES times.
- The RTL here is the FSM, counter, lane muxing and handshake (~150–250 lines).

Test Plan:
- Zero state: reset, then in_data=0 with in_valid=1 -> after 4 cycles out_valid=1, out_data=0x63636363636363636363636363636363.
- Ordering check: in_data=0x000102030405060708090a0b0c0d0e0f -> out_data=0x637c777bf26b6fc53001672bfed7ab76. Byte 0 maps 00->63, byte 15 maps 0f->76.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_data held constant and in_ready=0; then out_ready=1 -> out_valid drops the next cycle.
- Back-to-back: in_valid held with two states (0x00..00, then all 0xff) and out_ready=1 -> second state accepted on the first's handshake edge; second result is 0x16 repeated; no bubble beyond 16/LANES cycles.
- Reset mid-operation: drop rst_n 2 cycles into SUB -> next cycle out_valid=0, busy=0, out_data=0, in_ready=0 while reset is held; after release, a fresh 0x53 state gives 0xed in every byte.
- Parameter sweep: LANES=1, 2, 8 and 16 on the ordering vector -> identical out_data, with latency 16, 8, 2 and 1 cycles respectively.
